// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_pipe
//  Purpose  : Registered N-lane immediate generator for the decode stage.
//             Each accepted bundle has its per-lane immediates decoded from
//             ImmSrc and extended to DATA_WIDTH before it is registered.
//             A two-entry buffer (OUT + SKID) sits behind a valid/ready
//             handshake, so full throughput is kept while in_ready_o stays
//             a pure register output.
//  Ports    : clk_i, rst_ni (async, active-low), flush_i
//             in_valid_i / in_ready_o   - input bundle handshake
//             InstrVec_i  [LANES*32]    - lane k instruction at [32k+31:32k]
//             ImmSrcVec_i [LANES*3]     - lane k ImmSrc code
//             LaneMask_i  [LANES]       - lane k holds a real instruction
//             out_valid_o / out_ready_i - output bundle handshake
//             ImmExtVec_o [LANES*DATA_WIDTH], LaneMask_o, Illegal_o
//  Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*32-1:0]         InstrVec_i,
    input  logic [LANES*3-1:0]          ImmSrcVec_i,
    input  logic [LANES-1:0]            LaneMask_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0] ImmExtVec_o,
    output logic [LANES-1:0]            LaneMask_o,
    output logic [LANES-1:0]            Illegal_o
);

    // One buffered bundle: {immediates, lane mask, illegal flags}
    localparam int c_imm_w    = LANES * DATA_WIDTH;
    localparam int c_bundle_w = c_imm_w + 2 * LANES;

    // State encoding mirrors {SKID valid, OUT valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Immediate decode. Every case is first built as a 32-bit value already
    // sign-correct at bit 31 (zero-extended forms have bit 31 clear), so one
    // signed widening covers both RV32 and RV64, including U-type on RV64.
    // The opcode field [6:0] never contributes to an immediate.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] f_extend(
        input logic [31:7] ins,
        input logic [2:0]  src
    );
        logic [31:0] v;
        v = '0;
        case (src)
            3'b000: v = {{20{ins[31]}}, ins[31:20]};
            3'b001: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'b010: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'b011: v = {ins[31:12], 12'b0};
            3'b100: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'b101: v = {20'b0, ins[31:20]};
            3'b110: v = {27'b0, ins[19:15]};
            default: v = '0;
        endcase
        return DATA_WIDTH'($signed(v));
    endfunction

    logic [c_imm_w-1:0] w_imm;
    logic [LANES-1:0]   w_ill;
    logic [LANES-1:0]   w_unused_opcode;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [31:0] w_instr;
            logic [2:0]  w_src;
            assign w_instr = InstrVec_i[32*k +: 32];
            assign w_src   = ImmSrcVec_i[3*k +: 3];
            // Disabled lanes carry a zero immediate and never flag illegal
            assign w_imm[DATA_WIDTH*k +: DATA_WIDTH] =
                LaneMask_i[k] ? f_extend(w_instr[31:7], w_src) : '0;
            assign w_ill[k]           = LaneMask_i[k] & (w_src == 3'b111);
            assign w_unused_opcode[k] = ^w_instr[6:0];
        end
    endgenerate

    logic [c_bundle_w-1:0] w_in_bundle;
    assign w_in_bundle = {w_imm, LaneMask_i, w_ill};

    // ------------------------------------------------------------------------
    // Handshake / buffer control
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_in_xfer;
    logic   w_load_out_in;
    logic   w_load_out_skid;
    logic   w_load_skid;

    // Ready depends only on the state register, never on out_ready_i
    assign in_ready_o  = (r_state != ST_FULL);
    assign out_valid_o = (r_state != ST_EMPTY);
    assign w_in_xfer   = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_out_in = 1'b1;
                    w_state_nxt   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (out_ready_i) begin
                    // OUT drains this edge; a new bundle replaces it directly
                    if (w_in_xfer) begin
                        w_load_out_in = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end else if (w_in_xfer) begin
                    // OUT is stalled, so the arriving bundle parks in SKID
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready_i) begin
                    w_load_out_skid = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush overrides everything: nothing loads, both entries invalidate
        if (flush_i) begin
            w_load_out_in   = 1'b0;
            w_load_out_skid = 1'b0;
            w_load_skid     = 1'b0;
            w_state_nxt     = ST_EMPTY;
        end
    end

    // ------------------------------------------------------------------------
    // Bundle storage. OUT only changes on an explicit load, which keeps its
    // contents stable while the consumer stalls.
    // ------------------------------------------------------------------------
    logic [c_bundle_w-1:0] r_out;
    logic [c_bundle_w-1:0] r_skid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= '0;
        end else if (w_load_out_in) begin
            r_out <= w_in_bundle;
        end else if (w_load_out_skid) begin
            r_out <= r_skid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= w_in_bundle;
        end
    end

    assign ImmExtVec_o = r_out[c_bundle_w-1 -: c_imm_w];
    assign LaneMask_o  = r_out[2*LANES-1 -: LANES];
    assign Illegal_o   = r_out[LANES-1:0];

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
N-lane, registered immediate generator that succeeds the dual-lane combinational extender used at the decode stage of the superscalar core. Each cycle it accepts one bundle of LANES instructions with per-lane ImmSrc codes, and produces sign- or zero-extended immediates at DATA_WIDTH (RV32 or RV64). A valid/ready handshake with a 2-entry skid buffer lets decode-to-execute run at full throughput. Bundles can be flushed on redirect, and undefined ImmSrc codes are flagged.

Parameters:
DATA_WIDTH, 32, output immediate width; legal values 32 or 64; instruction width fixed at 32.
LANES, 2, number of instruction lanes per bundle; legal range 1..8.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_ni  input  1  asynchronous active-low reset.
flush_i  input  1  drops all buffered bundles and any bundle presented this cycle.
in_valid_i  input  1  input bundle valid.
in_ready_o  output  1  block can accept a bundle.
InstrVec_i  input  LANES*32  lane k instruction at [32k+31:32k].
ImmSrcVec_i  input  LANES*3  lane k ImmSrc at [3k+2:3k].
LaneMask_i  input  LANES  lane k holds a real instruction.
out_valid_o  output  1  output bundle valid.
out_ready_i  input  1  consumer accepts bundle.
ImmExtVec_o  output  LANES*DATA_WIDTH  lane k immediate at [DW*k+DW-1:DW*k].
LaneMask_o  output  LANES  registered copy of LaneMask_i.
Illegal_o  output  LANES  lane k is enabled and its ImmSrc is undefined.

Behaviour:
- ImmSrc decode per lane. Result is sign-extended from the MSB shown to DATA_WIDTH unless marked zero-extended:
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}; sign-extended above bit 31 when DATA_WIDTH=64.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 IZ: instr[31:20] zero-extended (shamt/unsigned uses).
  - 110 CSR zimm: instr[19:15] zero-extended.
  - 111: undefined; immediate = 0; Illegal_o[k] = LaneMask_i[k].
- Lanes with LaneMask_i[k]=0: immediate forced to 0, Illegal_o[k]=0.
- Transfer rules: input transfer when in_valid_i & in_ready_o & !flush_i; output transfer when out_valid_o & out_ready_i.
- Latency: exactly 1 cycle from input transfer to out_valid_o when the output register is empty or draining.
- Storage: output register (OUT) plus skid register (SKID). Each holds immediates, LaneMask and Illegal bits. Extension is computed before registering.
- States by {SKID valid, OUT valid}:
  - EMPTY: input transfer fills OUT -> ONE.
  - ONE, out_ready_i=1: input transfer refills OUT (stay ONE); otherwise -> EMPTY.
  - ONE, out_ready_i=0: input transfer goes to SKID -> FULL.
  - FULL, out_ready_i=1: SKID moves to OUT -> ONE.
  - FULL, out_ready_i=0: hold.
- in_ready_o = !SKID valid. It is registered, with no combinational path from out_ready_i.
- Bundle order is preserved; no bundle is duplicated or dropped except by flush.
- OUT contents must stay stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1: both valid bits clear at the next edge; any concurrent in_valid_i bundle is discarded. out_valid_o=0 and in_ready_o=1 the cycle after. Flush takes priority over every simultaneous event.
- Reset (async, any time including mid-stream): out_valid_o=0, in_ready_o=1, ImmExtVec_o=0, LaneMask_o=0, Illegal_o=0, SKID invalid.
- Illegal bundles are passed through normally; the block does not stall on them.

Test Plan:
- DATA_WIDTH=32, LANES=2:
  - Lane0 0xFFF00093/000 and lane1 0xFE20AC23/001, mask 11 -> next cycle out_valid_o=1, immediates 0xFFFFFFFF and 0xFFFFFFF8, Illegal_o=00.
  - Lane0 0xFFDFF06F/100 and lane1 0x123450B7/011 -> 0xFFFFFFFC and 0x12345000.
  - Lane0 0xFFF00093/101 and lane1 0x000FD073 (rs1 field = 0x1F)/110 -> 0x00000FFF and 0x0000001F.
  - Lane0 ImmSrc 111 with mask 01, lane1 ImmSrc 111 with mask 01 -> Illegal_o=01, both immediates 0.
- Backpressure: out_ready_i=0 while 3 bundles are offered back-to-back -> 2 accepted, in_ready_o=0 from the 3rd cycle. Raise out_ready_i -> the 2 bundles drain in order with stable data, then the 3rd is accepted.
- Flush with FULL buffer and a concurrent valid input -> next cycle out_valid_o=0, in_ready_o=1, and no bundle appears later.
- rst_ni asserted low mid-stream, asynchronously between edges -> outputs zero immediately.
- DATA_WIDTH=64, LANES=4: 0xFFF00093/000 -> 0xFFFFFFFFFFFFFFFF; 0x800000B7/011 -> 0xFFFFFFFF80000000.
- Randomised throughput check against a reference model over 10k bundles with random out_ready_i -> zero mismatches; 100% throughput when out_ready_i is held at 1.
